// File: rtl/uart_pkg.sv
// Shared types, oversampling constants and helpers for the UART transceiver.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 8;

  // Rounded clock divider producing one tick per 1/16 bit.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

  // Parity bit for a (zero-padded) data word; zero padding does not change parity.
  function automatic logic parity_bit(input parity_t mode, input logic [7:0] d);
    case (mode)
      PAR_EVEN: return ^d;
      PAR_ODD:  return ~^d;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO with occupancy count, synchronous active-high reset.
// Latency: a push is visible at pop_data/level the cycle after the push edge.
// Backpressure: push while full is dropped; pop while empty is ignored.
// Ports: clk/rst; push/push_data write side; pop/pop_data read side (pop_data is 0
// when empty); full/empty/level status, level is $clog2(DEPTH)+1 bits.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two and level never exceeds it, so the MSB alone means full.
  assign full     = level[AW];
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Buffered UART transceiver: configurable frame, 16x oversampled RX, internal loopback.
// Latency: TX line falls on the first tick after the byte lands in the TX FIFO; RX byte and flags appear one cycle after the stop-bit sample.
// Backpressure: tx_ready drops when the TX FIFO is full; RX frames arriving with the RX FIFO full are dropped and flagged as overrun.
// Ports: clk/rst; loopback_en; tx_data/tx_valid/tx_ready write side; rx_data/rx_valid/rx_ready
// read side; rx/tx serial pins; tx_busy; rx_frame_err/rx_parity_err/rx_overrun pulses; tx_level/rx_level.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int      CLK_HZ     = 100_000_000,
  parameter int      BAUD       = 115_200,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          loopback_en,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic                          rx,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int         DIV       = baud_div(CLK_HZ, BAUD);
  localparam int         CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic       HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [3:0] SP        = 4'(SAMPLE_POINT - 1);
  localparam logic [3:0] BIT_END   = 4'(OVERSAMPLE - 1);

  // Tick generator
  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // FIFOs
  logic                 tx_pop, tx_empty, tx_full;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_empty, rx_full;
  logic [DATA_BITS-1:0] rx_shift;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push(tx_valid && tx_ready), .push_data(tx_data),
    .pop(tx_pop), .pop_data(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push(rx_push), .push_data(rx_shift),
    .pop(rx_ready), .pop_data(rx_data),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  // TX FSM
  tx_state_t            tx_state;
  logic [3:0]           tx_tc;
  logic [2:0]           tx_bc;
  logic                 tx_sc;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_line, tx_bit_end, tx_load;
  logic                 lb_q;

  assign tx_bit_end = tick && (tx_tc == BIT_END);

  // A new frame starts from idle on a tick, or straight after the last stop bit.
  always_comb begin
    tx_load = 1'b0;
    if (!tx_empty) begin
      if (tx_state == TX_IDLE)      tx_load = tick;
      else if (tx_state == TX_STOP) tx_load = tx_bit_end && (tx_sc == LAST_STOP);
    end
  end

  assign tx_pop  = tx_load;
  assign tx_busy = (tx_state != TX_IDLE);
  assign tx      = lb_q ? 1'b1 : tx_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tc    <= '0;
      tx_bc    <= '0;
      tx_sc    <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      if (tx_state != TX_IDLE && tick) tx_tc <= tx_tc + 4'd1;
      if (tx_load) begin
        tx_state <= TX_START;
        tx_tc    <= '0;
        tx_shift <= tx_head;
        tx_par   <= parity_bit(PARITY, 8'(tx_head));
        tx_line  <= 1'b0;
      end else if (tx_bit_end) begin
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bc    <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          TX_DATA: begin
            if (tx_bc == LAST_BIT) begin
              tx_sc    <= 1'b0;
              tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
              tx_line  <= HAS_PAR ? tx_par : 1'b1;
            end else begin
              tx_bc    <= tx_bc + 3'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            tx_line  <= 1'b1;
          end
          TX_STOP: begin
            if (tx_sc == LAST_STOP) tx_state <= TX_IDLE;
            else                    tx_sc    <= 1'b1;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // RX synchroniser and source select; loopback taps the internal line directly.
  logic rx_s1, rx_s2, rx_in, rx_prev;

  assign rx_in = lb_q ? tx_line : rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_in;
    end
  end

  // RX FSM: start bit is confirmed half a bit after the edge, later bits one bit apart.
  rx_state_t  rx_state;
  logic [3:0] rx_tc;
  logic [2:0] rx_bc;
  logic       rx_par, rx_done, rx_stop_ok, rx_sample, par_bad;

  assign rx_sample = tick && (rx_tc == ((rx_state == RX_START) ? SP : BIT_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_tc      <= '0;
      rx_bc      <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_done    <= 1'b0;
      rx_stop_ok <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) rx_tc <= rx_tc + 4'd1;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_state <= RX_START;
            rx_tc    <= '0;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_tc    <= '0;
            rx_bc    <= '0;
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_tc    <= '0;
            rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
            if (rx_bc == LAST_BIT) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else                   rx_bc    <= rx_bc + 3'd1;
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_tc    <= '0;
            rx_par   <= rx_in;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Only the first stop bit is checked; a second one is just idle line.
          if (rx_sample) begin
            rx_done    <= 1'b1;
            rx_stop_ok <= rx_in;
            rx_state   <= rx_in ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_in) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame outcome, one cycle after the stop sample; frame error outranks parity, parity outranks overrun.
  assign par_bad = HAS_PAR && (rx_par != parity_bit(PARITY, 8'(rx_shift)));
  assign rx_push = rx_done && rx_stop_ok && !par_bad && !rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err  <= rx_done && !rx_stop_ok;
      rx_parity_err <= rx_done && rx_stop_ok && par_bad;
      rx_overrun    <= rx_done && rx_stop_ok && !par_bad && rx_full;
    end
  end

  // Loopback only switches while both directions are idle, so no frame is split.
  always_ff @(posedge clk) begin
    if (rst)                                            lb_q <= 1'b0;
    else if (tx_state == TX_IDLE && rx_state == RX_IDLE) lb_q <= loopback_en;
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed/random bench for uart_xcvr: 8E1 @16 clk/bit depth 16, and 7O2 @32 clk/bit depth 4.
// Expected line bits and received bytes come from a frame-builder model and scoreboard queues.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
`timescale 1ns/1ps
module tb_uart_xcvr;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       lb0, txv0, txr0, rxv0, rxr0, rxl0, tx0, busy0, fe0, pe0, ov0;
  logic [7:0] txd0, rxd0;
  logic [4:0] txlvl0, rxlvl0;

  logic       lb1, txv1, txr1, rxv1, rxr1, rxl1, tx1, busy1, fe1, pe1, ov1;
  logic [6:0] txd1, rxd1;
  logic [2:0] txlvl1, rxlvl1;

  uart_xcvr #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_EVEN),
              .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst(rst), .loopback_en(lb0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rxr0),
    .rx(rxl0), .tx(tx0), .tx_busy(busy0),
    .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_overrun(ov0),
    .tx_level(txlvl0), .rx_level(rxlvl0)
  );

  uart_xcvr #(.CLK_HZ(3_200_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(PAR_ODD),
              .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .loopback_en(lb1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_valid(rxv1), .rx_ready(rxr1),
    .rx(rxl1), .tx(tx1), .tx_busy(busy1),
    .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_overrun(ov1),
    .tx_level(txlvl1), .rx_level(rxlvl1)
  );

  int checks = 0;
  int errors = 0;

  // Pulse and activity counters
  int busy_c0 = 0, txlow_c0 = 0;
  int fe_c0 = 0, pe_c0 = 0, ov_c0 = 0, fe_c1 = 0, pe_c1 = 0, ov_c1 = 0;
  always @(posedge clk) begin
    if (busy0 === 1'b1) busy_c0  <= busy_c0 + 1;
    if (tx0 === 1'b0)   txlow_c0 <= txlow_c0 + 1;
    if (fe0 === 1'b1)   fe_c0 <= fe_c0 + 1;
    if (pe0 === 1'b1)   pe_c0 <= pe_c0 + 1;
    if (ov0 === 1'b1)   ov_c0 <= ov_c0 + 1;
    if (fe1 === 1'b1)   fe_c1 <= fe_c1 + 1;
    if (pe1 === 1'b1)   pe_c1 <= pe_c1 + 1;
    if (ov1 === 1'b1)   ov_c1 <= ov_c1 + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running after 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  // pm: 0 none, 1 odd, 2 even.
  logic frame_q[$];
  task automatic build_frame(input logic [7:0] d, input int nb, input int pm, input int ns);
    int ones;
    ones = 0;
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      frame_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 1) frame_q.push_back((ones % 2) == 0);
    if (pm == 2) frame_q.push_back((ones % 2) == 1);
    for (int i = 0; i < ns; i++) frame_q.push_back(1'b1);
  endtask

  task automatic drive_frame(input int sel, input int cpb);
    foreach (frame_q[k]) begin
      if (sel == 0) rxl0 = frame_q[k];
      else          rxl1 = frame_q[k];
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic tx_frame_check(input logic [7:0] d);
    int lat, b0;
    build_frame(d, 8, 2, 1);
    b0 = busy_c0;
    txd0 = d; txv0 = 1'b1;
    @(negedge clk);
    txv0 = 1'b0;
    chk("tx_level_after_write", txlvl0, 1);
    lat = 0;
    while (tx0 !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("tx_start_latency", (lat >= 1 && lat <= 3), 1);
    repeat (8) @(negedge clk);
    foreach (frame_q[k]) begin
      chk($sformatf("tx_bit%0d_of_%02h", k, d), tx0, frame_q[k]);
      chk("tx_busy_in_frame", busy0, 1);
      repeat (16) @(negedge clk);
    end
    chk("tx_idle_after_frame", tx0, 1);
    chk("tx_busy_after_frame", busy0, 0);
    chk("tx_busy_cycles", busy_c0 - b0, 176);
  endtask

  initial begin
    logic [7:0] sb[$];
    logic [7:0] d;
    int got, b0, t0, f0, p0, o0, n;

    rst = 1'b1;
    lb0 = 0; txv0 = 0; rxr0 = 0; rxl0 = 1; txd0 = '0;
    lb1 = 0; txv1 = 0; rxr1 = 0; rxl1 = 1; txd1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx0, 1);
    chk("rst_tx_ready", txr0, 1);
    chk("rst_tx_busy", busy0, 0);
    chk("rst_rx_valid", rxv0, 0);
    chk("rst_rx_data", rxd0, 0);
    chk("rst_levels", {txlvl0, rxlvl0}, 0);
    chk("rst_flags", {fe0, pe0, ov0}, 0);
    chk("rst_u1_tx_rxlevel", {tx1, rxlvl1}, 4'b1000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Transmit on the pin: fixed pattern, then a random byte.
    tx_frame_check(8'hA5);
    tx_frame_check(8'($urandom));

    // Loopback: five back-to-back frames must come back in order, nothing on the pin.
    lb0 = 1; rxr0 = 1;
    repeat (2) @(negedge clk);
    sb = '{8'h00, 8'hFF, 8'h3C, 8'($urandom), 8'($urandom)};
    b0 = busy_c0; t0 = txlow_c0; f0 = fe_c0; p0 = pe_c0; o0 = ov_c0;
    foreach (sb[i]) begin
      txd0 = sb[i]; txv0 = 1'b1;
      @(negedge clk);
    end
    txv0 = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 1200 && got < 5; cyc++) begin
      if (rxv0 === 1'b1) begin
        chk($sformatf("lb_data%0d", got), rxd0, sb.pop_front());
        got++;
      end
      @(negedge clk);
    end
    chk("lb_count", got, 5);
    for (int cyc = 0; cyc < 300 && busy0 === 1'b1; cyc++) @(negedge clk);
    chk("lb_busy_no_gap", busy_c0 - b0, 5 * 176);
    chk("lb_pin_high", txlow_c0 - t0, 0);
    chk("lb_no_errors", (fe_c0 - f0) + (pe_c0 - p0) + (ov_c0 - o0), 0);
    lb0 = 0; rxr0 = 0;
    repeat (2) @(negedge clk);

    // 8E1 external: bad parity dropped, then the same byte with good parity accepted.
    d = 8'($urandom);
    p0 = pe_c0; f0 = fe_c0;
    build_frame(d, 8, 2, 1);
    frame_q[9] = ~frame_q[9];
    drive_frame(0, 16);
    repeat (32) @(negedge clk);
    chk("u0_parity_err_pulse", pe_c0 - p0, 1);
    chk("u0_parity_err_dropped", rxlvl0, 0);
    build_frame(d, 8, 2, 1);
    drive_frame(0, 16);
    repeat (32) @(negedge clk);
    chk("u0_good_level", rxlvl0, 1);
    chk("u0_good_data", rxd0, d);
    chk("u0_no_extra_errors", (pe_c0 - p0) + (fe_c0 - f0), 1);
    rxr0 = 1; @(negedge clk); rxr0 = 0;
    chk("u0_pop_level", rxlvl0, 0);

    // Frame error then a long break; the following 0x55 must arrive cleanly.
    f0 = fe_c0; p0 = pe_c0; o0 = ov_c0;
    build_frame(8'($urandom), 8, 2, 1);
    frame_q[10] = 1'b0;
    drive_frame(0, 16);
    repeat (40 * 16) @(negedge clk);
    rxl0 = 1'b1;
    repeat (32) @(negedge clk);
    chk("frame_err_pulse", fe_c0 - f0, 1);
    chk("frame_err_dropped", rxlvl0, 0);
    build_frame(8'h55, 8, 2, 1);
    drive_frame(0, 16);
    repeat (32) @(negedge clk);
    chk("after_break_errors", (fe_c0 - f0) + (pe_c0 - p0) + (ov_c0 - o0), 1);
    chk("after_break_level", rxlvl0, 1);
    chk("after_break_data", rxd0, 8'h55);

    // 7O2: 0x01 with parity bit 1 is wrong, with 0 is right.
    p0 = pe_c1;
    build_frame(8'h01, 7, 1, 2);
    frame_q[8] = 1'b1;
    drive_frame(1, 32);
    repeat (64) @(negedge clk);
    chk("u1_parity_err_pulse", pe_c1 - p0, 1);
    chk("u1_parity_err_level", rxlvl1, 0);
    build_frame(8'h01, 7, 1, 2);
    drive_frame(1, 32);
    repeat (64) @(negedge clk);
    chk("u1_good_level", rxlvl1, 1);
    chk("u1_good_data", rxd1, 7'h01);
    rxr1 = 1; @(negedge clk); rxr1 = 0;

    // Overrun: five frames into a depth-4 FIFO with no reads.
    f0 = fe_c1; p0 = pe_c1; o0 = ov_c1;
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      sb.push_back(8'($urandom_range(0, 127)));
      build_frame(sb[i], 7, 1, 2);
      drive_frame(1, 32);
    end
    repeat (64) @(negedge clk);
    chk("ovr_level", rxlvl1, 4);
    chk("ovr_pulse", ov_c1 - o0, 1);
    chk("ovr_other_errors", (fe_c1 - f0) + (pe_c1 - p0), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr_valid%0d", i), rxv1, 1);
      chk($sformatf("ovr_data%0d", i), rxd1, sb[i][6:0]);
      rxr1 = 1; @(negedge clk); rxr1 = 0;
    end
    chk("ovr_drained", rxlvl1, 0);

    // Fill the TX FIFO, then reset during the second start bit.
    n = 0;
    while (txr0 === 1'b1 && n < 24) begin
      txd0 = 8'($urandom); txv0 = 1'b1;
      @(negedge clk);
      n++;
    end
    txv0 = 1'b0;
    chk("fill_level", txlvl0, 16);
    chk("fill_ready_low", txr0, 0);
    for (int cyc = 0; cyc < 400 && txlvl0 !== 5'd15; cyc++) @(negedge clk);
    chk("second_start_bit", {txlvl0, tx0}, {5'd15, 1'b0});
    chk("rx_level_before_rst", rxlvl0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_levels", {txlvl0, rxlvl0}, 0);
    chk("midrst_ready", txr0, 1);
    chk("midrst_rx_valid", rxv0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised UART transceiver core: buffered TX and RX paths, configurable frame format (data bits, parity, stop bits), 16x oversampled receiver with error detection, and an internal loopback mode. Successor to the fixed-format UART used on the Basys3 board top. The board wrapper instantiates it between the `RsRx`/`RsTx` pins and the command/display logic.

## Interface
- `CLK_HZ`, 100_000_000 — input clock frequency.
- `BAUD`, 115_200 — line rate; `DIV = round(CLK_HZ/(BAUD*16))`, must be ≥1.
- `DATA_BITS`, 8 — legal range 5..8.
- `PARITY`, `PAR_NONE` — one of `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
- `STOP_BITS`, 1 — 1 or 2.
- `FIFO_DEPTH`, 16 — TX and RX FIFO depth; power of two, ≥2.
- `clk` in 1 — single clock domain.
- `rst` in 1 — synchronous, active-high reset.
- `loopback_en` in 1 — 1: receiver fed from internal TX serial line, `tx` pin held 1.
- `tx_data` in DATA_BITS — byte to send.
- `tx_valid` in 1 / `tx_ready` out 1 — write handshake; `tx_ready = !tx_fifo_full`.
- `rx_data` out DATA_BITS — head of RX FIFO (first-word fall-through).
- `rx_valid` out 1 / `rx_ready` in 1 — read handshake; `rx_valid = !rx_fifo_empty`.
- `rx` in 1 — serial input, asynchronous.
- `tx` out 1 — serial output.
- `tx_busy` out 1 — high from start-bit start until last stop-bit end.
- `rx_frame_err`, `rx_parity_err`, `rx_overrun` out 1 each — one-cycle pulses.
- `tx_level`, `rx_level` out $clog2(FIFO_DEPTH)+1 — FIFO occupancy.

## Operation
- Tick generator: free-running counter 0..DIV-1; `tick` pulses once per wrap. Each bit lasts 16 ticks.
- TX FSM: `TX_IDLE → TX_START → TX_DATA → [TX_PARITY] → TX_STOP → TX_IDLE`, or `TX_STOP → TX_START` if the FIFO is non-empty.
  - Pop occurs on the `TX_IDLE → TX_START` transition.
  - Data is sent LSB first.
  - Parity bit: odd/even over the data bits.
  - `STOP_BITS` stop bits of 1.
- RX input: 2-FF synchroniser, reset value 1.
- RX FSM: `RX_IDLE → RX_START → RX_DATA → [RX_PARITY] → RX_STOP → RX_IDLE`.
  - A falling edge in `RX_IDLE` starts tick count.
  - Start bit is re-checked at tick 8. If it reads 1, the start is false and the FSM returns to `RX_IDLE`.
  - Data, parity and stop are sampled at tick 8 of each bit.
  - With 2 stop bits, only the first stop bit is checked.
- Stop-bit outcomes, in priority order (only one flag pulses):
  - Stop sampled 0: `rx_frame_err`; frame discarded; go to `RX_BREAK` until the line reads 1, then `RX_IDLE`.
  - Parity mismatch: `rx_parity_err`; frame discarded.
  - RX FIFO full: `rx_overrun`; frame discarded; FIFO contents untouched.
  - Otherwise: frame pushed to the RX FIFO.
- FIFOs:
  - A push when full is impossible on TX (gated by `tx_ready`) and is dropped on RX (overrun).
  - Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
  - Push to an empty FIFO makes `rx_valid` rise on the next cycle.
- `loopback_en` is sampled into an internal register only when both FSMs are idle. A mid-frame change is deferred.
- Unused upper bits of `rx_data` are not applicable; the width equals DATA_BITS exactly.

## Timing
- Reset values:
  - `tx=1`, `tx_ready=1`, `tx_busy=0`, `rx_valid=0`, `rx_data=0`.
  - All error flags 0; levels 0; FSMs idle; tick counter 0.
  - FIFOs cleared; loopback register 0.
- Reset mid-frame: `tx=1` from the cycle after the `rst` edge. The partial frame is lost.
- TX latency: handshake at edge N → `tx_level` increments at N+1 → `tx` falls on the first tick after N+1. Worst case is DIV+2 cycles.
- Frame length: `16*(1+DATA_BITS+P+STOP_BITS)` ticks, where P = 0 or 1. Back-to-back frames have no idle gap.
- RX latency: the stop-bit centre sample is registered at edge S.
  - FIFO write and flag pulse occur at S+1.
  - `rx_valid` and `rx_data` are valid at S+1.
- `rx_data` and `rx_level` update in the cycle after a pop.

## Structure
- Package `uart_pkg` contains:
  - `parity_t` (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
  - `tx_state_t` and `rx_state_t` enums.
  - `localparam OVERSAMPLE = 16`.
  - `SAMPLE_POINT = 8`.
- Sub-module `uart_fifo` is parametrised by WIDTH and DEPTH, uses a synchronous reset, and is first-word fall-through. It is instantiated twice (TX and RX).
- Tick generator, TX FSM, RX FSM and synchroniser live inline in `uart_xcvr`.

## Test plan
- 8N1, `CLK_HZ=1_600_000`, `BAUD=100_000` (DIV=1, 16 clk/bit). Write 0xA5 → `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each held 16 cycles; `tx_busy` high for 160 cycles.
- 8E1 loopback. Write 0x00, 0xFF, 0x3C with `rx_ready=1` → `rx_data` returns 0x00, 0xFF, 0x3C in order; no error pulses; `tx` pin stays 1.
- 8O1 external RX. Drive 0x01 with parity bit 1 → exactly one `rx_parity_err` pulse; `rx_level` stays 0. Resend with parity bit 0 → 0x01 received.
- Drive a frame with stop=0 → one `rx_frame_err` pulse. Hold `rx` low for 40 bit times, then release, then send 0x55 → no further errors; 0x55 received.
- `FIFO_DEPTH=4`, `rx_ready=0`, send 0x10..0x14 → `rx_level=4`; one `rx_overrun` at the fifth stop bit. Draining yields 0x10..0x13.
- Write 16 bytes back-to-back → `tx_ready` low once `tx_level=16`. Assert `rst` mid-start-bit → next cycle `tx=1`, `tx_busy=0`, both levels 0, `tx_ready=1`.
